// File: rtl/key_reduce_ctrl.sv
// Key assembly controller: gathers sixteen 32-bit words into a 512-bit key,
// waits RED_LAT cycles for the reduction datapath, then holds the reduced result.
module key_reduce_ctrl #(
  parameter int RED_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic [511:0] key_out,
  input  logic [31:0]  red_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy,
  output logic         frame_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid may be raised at any time and is held until the transfer.

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [3:0]     lat;
  logic [511:0]   key_q;

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign key_out  = key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= 4'd0;
      lat       <= 4'd0;
      key_q     <= '0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            key_q[32*cnt +: 32] <= in_data;
            // in_last must coincide exactly with the 16th word
            if (in_last != (cnt == 4'd15)) begin
              frame_err <= 1'b1;
              cnt       <= 4'd0;
            end else if (in_last) begin
              cnt   <= 4'd0;
              lat   <= 4'(RED_LAT);
              state <= RUN;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        RUN: begin
          if (lat == 4'd0) begin
            out_data  <= red_in;
            out_valid <= 1'b1;
            key_q     <= '0;
            state     <= DONE;
          end else begin
            lat <= lat - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
